// File: rtl/fir_filter.sv
// Transposed-form FIR filter.
// Each tap multiplies the registered input sample by its coefficient and adds
// the partial sum of the tap behind it. The critical path is therefore one
// multiply plus one add for any tap count. Every sum is carried at 40 bits,
// which is exact for up to 256 taps of 16x16 products.
module fir_filter #(
   parameter int                 NUM_TAPS = 16,
   parameter logic signed [15:0] COEFFS [NUM_TAPS] = '{
      16'sd1,  16'sd2,  16'sd3,  16'sd4,  16'sd5,  16'sd6,  16'sd7,  16'sd8,
      16'sd9,  16'sd10, 16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16
   }
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] inp,
   output logic signed [39:0] outp
);

   // Registered input sample, shared by every tap multiplier
   logic signed [15:0] x_q;
   logic signed [15:0] x_d;

   // Partial-sum chain; s_q[0] is the filter output
   logic signed [39:0] s_q [NUM_TAPS];
   logic signed [39:0] s_d [NUM_TAPS];

   // Per-tap full-precision products
   logic signed [31:0] prod_s [NUM_TAPS];

   // Partial sums extended with a zero entry past the last tap
   logic signed [39:0] s_ext_s [NUM_TAPS+1];

   // Next-state logic: load the new sample, then multiply-accumulate each tap
   always_comb begin
      x_d = inp;
      for (int k = 0; k <= NUM_TAPS; k++) begin
         if (k < NUM_TAPS) begin
            s_ext_s[k] = s_q[k];
         end else begin
            s_ext_s[k] = 40'sd0;
         end
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
         prod_s[k] = 32'(COEFFS[k]) * 32'(x_q);
         s_d[k]    = 40'(prod_s[k]) + s_ext_s[k+1];
      end
   end

   // State registers with synchronous reset that discards all history
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q <= 16'sd0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            s_q[k] <= 40'sd0;
         end
      end else begin
         x_q <= x_d;
         for (int k = 0; k < NUM_TAPS; k++) begin
            s_q[k] <= s_d[k];
         end
      end
   end

   // Output taken straight from the head of the partial-sum chain
   assign outp = s_q[0];

endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed stimulus, direct-form
// convolution reference model, and an expected-value queue per clock.
module tb_fir_filter;

   logic               clk;
   logic               rst;
   logic signed [15:0] inp;
   logic signed [39:0] outp;
   logic signed [39:0] outp_big;

   int checks   = 0;
   int failures = 0;

   int                 coef [16];
   longint             hist [$];
   logic signed [39:0] exp_q [$];

   fir_filter u_dut (
      .clk  (clk),
      .rst  (rst),
      .inp  (inp),
      .outp (outp)
   );

   fir_filter #(
      .NUM_TAPS (256),
      .COEFFS   ('{default: 16'sh8000})
   ) u_big (
      .clk  (clk),
      .rst  (rst),
      .inp  (inp),
      .outp (outp_big)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [39:0] obs,
                      input logic signed [39:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic signed [39:0] model_y();
      longint acc = 0;
      for (int k = 0; k < hist.size(); k++) begin
         acc += longint'(coef[k]) * hist[k];
      end
      return 40'(acc);
   endfunction

   // One clock: drive inputs, advance, update model, compare scoreboard head
   task automatic step(input bit r, input logic signed [15:0] x);
      logic signed [39:0] e;
      rst = r;
      inp = x;
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         hist.delete();
         chk("reset_out", outp, 40'sd0);
         exp_q.push_back(40'sd0);
      end else begin
         hist.push_front(longint'(x));
         if (hist.size() > 16) void'(hist.pop_back());
         exp_q.push_back(model_y());
         e = exp_q.pop_front();
         chk("scoreboard", outp, e);
      end
   endtask

   initial begin
      logic signed [15:0] sx;
      for (int k = 0; k < 16; k++) coef[k] = k + 1;
      rst = 1'b1;
      inp = 16'sd0;

      // Reset with a non-zero input that must be ignored
      step(1'b1, 16'sd12345);
      step(1'b1, -16'sd2222);

      // Zero input held
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 16'sd0);
         chk("zero_hold", outp, 40'sd0);
      end

      // Impulse response: 1..16, then zero
      step(1'b1, 16'sd0);
      step(1'b1, 16'sd0);
      step(1'b0, 16'sd1);
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 16'sd0);
         chk("impulse", outp, (i <= 16) ? 40'(i) : 40'sd0);
      end

      // Step response ramp to 13600
      step(1'b1, 16'sd0);
      step(1'b0, 16'sd100);
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 16'sd100);
         chk("step_ramp", outp,
             (k < 16) ? 40'(100 * (k + 1) * (k + 2) / 2) : 40'sd13600);
      end

      // Mid-stream reset during a step: output clears, ramp restarts
      step(1'b1, 16'sd100);
      chk("midreset_zero", outp, 40'sd0);
      step(1'b0, 16'sd100);
      chk("midreset_rel", outp, 40'sd0);
      step(1'b0, 16'sd100);
      chk("midreset_r1", outp, 40'sd100);
      step(1'b0, 16'sd100);
      chk("midreset_r2", outp, 40'sd300);
      step(1'b0, 16'sd100);
      chk("midreset_r3", outp, 40'sd600);

      // Largest single product on the 256-tap instance
      step(1'b1, 16'sd0);
      step(1'b0, 16'sh8000);
      step(1'b0, 16'sd0);
      chk("big_product", outp_big, 40'sd1073741824);

      // Negative full scale held: steady on both instances
      step(1'b1, 16'sd0);
      for (int i = 0; i < 262; i++) step(1'b0, 16'sh8000);
      chk("negfs_steady", outp, -40'sd4456448);
      chk("big_steady", outp_big, 40'sd274877906944);

      // Sine sweep against the reference model
      step(1'b1, 16'sd0);
      for (int f = 1; f <= 26; f++) begin
         for (int t = 0; t < 2000; t++) begin
            sx = 16'($rtoi(30000.0 * $sin(2.0 * 3.14159265358979 * f * t / 27.0)));
            step(1'b0, sx);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 The block SHALL have parameter NUM_TAPS, default 16, giving the tap count, legal range 1..256.
REQ-002 The block SHALL have parameter COEFFS, an array of NUM_TAPS signed 16-bit values, default COEFFS[k] = k+1 (1..16), giving the tap coefficients c[0]..c[NUM_TAPS-1].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 inp  input  16  signed two's-complement input sample, one new sample per clock.
REQ-006 outp  output  40  signed two's-complement filtered output, registered.

Function
REQ-007 The block SHALL compute y[n] = sum over k=0..NUM_TAPS-1 of c[k]*x[n-k], where x[n] is inp sampled at rising edge n and x[m]=0 for samples before the last reset.
REQ-008 The block SHALL use a transposed-form pipeline: input register x_reg, one multiplier per tap, and partial-sum registers s[0..NUM_TAPS-1].
REQ-009 The update at each rising edge SHALL be s[k] <= c[k]*x_reg + s[k+1] for k < NUM_TAPS-1, and s[NUM_TAPS-1] <= c[NUM_TAPS-1]*x_reg.
REQ-010 outp SHALL be driven directly from s[0], with no combinational path from inp to outp.
REQ-011 Latency SHALL be 2 edges: inp sampled at edge n appears as y[n] on outp after edge n+1, and outp is stable until edge n+2.
REQ-012 The block SHALL accept a new sample on every clock, with no stall, valid, or handshake signals.
REQ-013 Products SHALL be full-precision 32-bit signed, sign-extended to 40 bits before addition.
REQ-014 All partial sums SHALL be 40-bit signed, with no rounding, truncation, or saturation.
REQ-015 Overflow SHALL wrap as two's complement; 40 bits are exact for NUM_TAPS <= 256 at any 16-bit input and coefficient.
REQ-016 The critical path SHALL be one multiply plus one add between registers, independent of NUM_TAPS.
REQ-017 Changing COEFFS SHALL require no RTL edits; taps SHALL be generated from the parameters.
REQ-018 Input -32768 times coefficient -32768 SHALL produce +1073741824 exactly.
REQ-019 For a held constant input X, outp SHALL reach the steady value X*sum(c[k]) after edge NUM_TAPS of the hold and remain there.

Reset
REQ-020 When rst=1 at a rising edge, x_reg and all s[k] SHALL become 0 at that edge.
REQ-021 outp SHALL read 0 from the first edge with rst=1 until the first post-reset sample propagates.
REQ-022 inp SHALL be ignored on any edge where rst=1.
REQ-023 Reset asserted mid-stream SHALL discard all history, so the response after release equals that of a freshly reset filter.
REQ-024 Without reset, register contents SHALL be don't-care; the bench SHALL apply rst for at least 2 cycles first.

Verification
REQ-025 Reset, then inp=0 held -> outp=0 on every cycle.
REQ-026 Impulse: inp=1 for one cycle at edge n, 0 afterwards -> outp after edges n+1..n+16 = 1,2,...,16, then 0 thereafter.
REQ-027 Step: inp=100 held from edge n -> outp after edge n+1+k = 100*(k+1)(k+2)/2, reaching steady 13600 after edge n+16.
REQ-028 Negative full-scale: inp=-32768 held -> steady outp = -4456448, with no wrap; with all COEFFS=-32768, NUM_TAPS=256 -> steady +274877906944.
REQ-029 Reset mid-operation: during the REQ-027 step, assert rst for one edge -> outp=0 after that edge; after release, the ramp restarts 100, 300, 600, ...
REQ-030 Sine sweep: 16-bit sinusoid inputs at frequencies i/27 of fs, i=1..26, with 2000 cycles per frequency -> outp bit-exact to a reference convolution model on every cycle after latency.
